// File: rtl/ir_cmd_ctrl_pkg.sv
// Shared definitions for the NEC IR command controller.
// Holds NEC frame field offsets, command width, FSM encodings and helpers.
package ir_cmd_ctrl_pkg;

    // NEC frame byte offsets inside the 32-bit burst
    localparam int ADDR_LSB  = 0;
    localparam int NADDR_LSB = 8;
    localparam int CMD_LSB   = 16;
    localparam int NCMD_LSB  = 24;
    localparam int CMD_W     = 8;

    // FSM encodings
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    // Registered result of the frame check stage
    typedef struct packed {
        logic             frm;
        logic             rpt;
        logic             ok;
        logic             addr_ok;
        logic [CMD_W-1:0] cmd;
    } chk_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/ir_cmd_ctrl_fifo.sv
// Small show-ahead command FIFO with registered storage.
// Ports: clk, rst, push/din, pop, dout (head), full, empty.
module ir_cmd_ctrl_fifo
    import ir_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             wr;
    logic             rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign rd    = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves this cycle
    assign wr    = push & (~full | rd);
    assign dout  = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (rd)
                rptr <= rptr + 1'b1;
            unique case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// NEC command sequencer: checks frames, tracks key hold, auto-repeats, queues.
// Ports: clk, rst, burst/burst_vld, repeat_vld, cmd/cmd_vld/cmd_rdy, held, overflow, err_cnt.
module ir_cmd_ctrl
    import ir_cmd_ctrl_pkg::*;
#(
    parameter int         CLK_HZ       = 12_000_000,
    parameter logic [7:0] ADDR         = 8'h00,
    parameter bit         ADDR_FILTER  = 1'b1,
    parameter int         HOLD_MS      = 120,
    parameter int         REPEAT_DELAY = 4,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] burst,
    input  logic        burst_vld,
    input  logic        repeat_vld,
    output logic [8:0]  cmd,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    output logic        held,
    output logic        overflow,
    output logic [7:0]  err_cnt
);

    localparam int HOLD_CYCLES = CLK_HZ / 1000 * HOLD_MS;
    localparam int TW          = clog2(HOLD_CYCLES + 1);

    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] ONE     = TW'(1);
    localparam logic [3:0]    REP_N   = 4'(REPEAT_DELAY);

    logic [CMD_W-1:0] f_addr;
    logic [CMD_W-1:0] f_naddr;
    logic [CMD_W-1:0] f_cmd;
    logic [CMD_W-1:0] f_ncmd;

    chk_t             chk;
    logic [0:0]       state;
    logic [TW-1:0]    timer;
    logic [3:0]       rep_cnt;
    logic [CMD_W-1:0] last_cmd;

    logic             accept;
    logic             rpt_push;
    logic             push;
    logic [8:0]       push_data;
    logic             pop;
    logic             full;
    logic             empty;

    assign f_addr  = burst[ADDR_LSB  +: CMD_W];
    assign f_naddr = burst[NADDR_LSB +: CMD_W];
    assign f_cmd   = burst[CMD_LSB   +: CMD_W];
    assign f_ncmd  = burst[NCMD_LSB  +: CMD_W];

    // Check stage; a repeat arriving with a frame is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk <= '0;
        end else begin
            chk.frm     <= burst_vld;
            chk.rpt     <= repeat_vld & ~burst_vld;
            chk.ok      <= (f_naddr == ~f_addr) & (f_ncmd == ~f_cmd);
            chk.addr_ok <= ~ADDR_FILTER | (f_addr == ADDR);
            chk.cmd     <= f_cmd;
        end
    end

    assign accept    = chk.frm & chk.ok & chk.addr_ok;
    assign rpt_push  = chk.rpt & (state == S_HELD) & (rep_cnt >= REP_N);
    assign push      = accept | rpt_push;
    assign push_data = accept ? {1'b0, chk.cmd} : {1'b1, last_cmd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            rep_cnt  <= '0;
            last_cmd <= '0;
        end else if (accept) begin
            state    <= S_HELD;
            timer    <= HOLD_LD;
            rep_cnt  <= '0;
            last_cmd <= chk.cmd;
        end else if (state == S_HELD) begin
            if (chk.rpt) begin
                timer <= HOLD_LD;
                if (rep_cnt < REP_N)
                    rep_cnt <= rep_cnt + 1'b1;
            end else if (timer <= ONE) begin
                // Held for exactly HOLD_CYCLES cycles after the last reload
                state <= S_IDLE;
                timer <= '0;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (chk.frm & ~chk.ok & (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 1'b1;
            if (push & full & ~pop)
                overflow <= 1'b1;
        end
    end

    assign held    = (state == S_HELD);
    assign cmd_vld = ~empty;
    assign pop     = cmd_vld & cmd_rdy;

    ir_cmd_ctrl_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (cmd),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Directed self-checking bench for ir_cmd_ctrl.
// Uses a scaled clock rate so hold windows fit a short run.
module tb_ir_cmd_ctrl;

    localparam int CLK_HZ  = 50_000;
    localparam int HOLD    = CLK_HZ / 1000 * 120;
    localparam int RPT_GAP = CLK_HZ / 1000 * 108;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] burst = '0;
    logic        burst_vld = 1'b0;
    logic        repeat_vld = 1'b0;
    logic [8:0]  cmd;
    logic        cmd_vld;
    logic        cmd_rdy = 1'b0;
    logic        held;
    logic        overflow;
    logic [7:0]  err_cnt;

    int n_run  = 0;
    int n_fail = 0;

    logic [8:0] got_q[$];

    ir_cmd_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .ADDR         (8'h00),
        .ADDR_FILTER  (1'b1),
        .HOLD_MS      (120),
        .REPEAT_DELAY (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .burst      (burst),
        .burst_vld  (burst_vld),
        .repeat_vld (repeat_vld),
        .cmd        (cmd),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .held       (held),
        .overflow   (overflow),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Record every accepted command between clock edges
    always @(negedge clk)
        if (!rst && cmd_vld && cmd_rdy)
            got_q.push_back(cmd);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame(input logic [7:0] c,
                                          input logic [7:0] a);
        return {~c, c, ~a, a};
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        burst_vld  = 1'b0;
        repeat_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic send(input logic [31:0] b);
        burst     = b;
        burst_vld = 1'b1;
        @(posedge clk);
        #1;
        burst_vld = 1'b0;
    endtask

    task automatic send_rpt();
        repeat_vld = 1'b1;
        @(posedge clk);
        #1;
        repeat_vld = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_vld", 32'(cmd_vld), 0);
        chk("rst_held", 32'(held), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_cmd", 32'(cmd), 0);

        // Good frame: cmd_vld at N+2
        cmd_rdy = 1'b1;
        send(32'hBF40FF00);
        @(negedge clk);
        chk("lat_n1", 32'(cmd_vld), 0);
        @(negedge clk);
        chk("lat_n2", 32'(cmd_vld), 1);
        chk("cmd040", 32'(cmd), 32'h040);
        chk("held1", 32'(held), 1);

        // Corrupt cmd inverse
        send(32'hBF41FF00);
        repeat (3) @(negedge clk);
        chk("err_inc", 32'(err_cnt), 1);
        chk("err_held", 32'(held), 1);
        chk("err_nocmd", got_q.size(), 1);

        // Address filtered
        send(frame(8'h40, 8'h10));
        repeat (3) @(negedge clk);
        chk("flt_err", 32'(err_cnt), 1);
        chk("flt_nocmd", got_q.size(), 1);

        // Auto-repeat after 4 swallowed repeats
        do_reset();
        cmd_rdy = 1'b1;
        send(32'hBF40FF00);
        for (int i = 0; i < 6; i++) begin
            repeat (RPT_GAP) @(posedge clk);
            #1;
            send_rpt();
        end
        repeat (10) @(negedge clk);
        chk("rpt_cnt", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("rpt_0", 32'(got_q[0]), 32'h040);
            chk("rpt_1", 32'(got_q[1]), 32'h140);
            chk("rpt_2", 32'(got_q[2]), 32'h140);
        end
        chk("rpt_held", 32'(held), 1);

        // Hold timeout, then late repeat
        do_reset();
        send(32'hBF40FF00);
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        chk("to_still", 32'(held), 1);
        @(posedge clk);
        @(negedge clk);
        chk("to_drop", 32'(held), 0);
        send_rpt();
        repeat (5) @(negedge clk);
        chk("late_rpt", got_q.size(), 1);
        chk("late_held", 32'(held), 0);

        // Overflow and ordered drain
        do_reset();
        cmd_rdy = 1'b0;
        for (int i = 1; i <= 5; i++)
            send(frame(8'(i), 8'h00));
        repeat (3) @(negedge clk);
        chk("ovf", 32'(overflow), 1);
        chk("ovf_vld", 32'(cmd_vld), 1);
        chk("ovf_head", 32'(cmd), 32'h001);
        cmd_rdy = 1'b1;
        repeat (8) @(negedge clk);
        chk("drain_n", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk($sformatf("drain_%0d", i), 32'(got_q[i]), i + 1);
        chk("drain_vld", 32'(cmd_vld), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Frame and repeat together: frame only
        do_reset();
        cmd_rdy = 1'b1;
        send(32'hBF40FF00);
        repeat (3) @(negedge clk);
        burst      = frame(8'h22, 8'h00);
        burst_vld  = 1'b1;
        repeat_vld = 1'b1;
        @(posedge clk);
        #1;
        burst_vld  = 1'b0;
        repeat_vld = 1'b0;
        repeat (5) @(negedge clk);
        chk("sim_n", got_q.size(), 2);
        if (got_q.size() == 2)
            chk("sim_cmd", 32'(got_q[1]), 32'h022);

        // err_cnt saturates
        do_reset();
        for (int i = 0; i < 300; i++)
            send(32'hBF41FF00);
        repeat (3) @(negedge clk);
        chk("err_sat", 32'(err_cnt), 255);
        chk("err_none", got_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
